// File: rtl/context_exchange_ctrl.sv
// Preemption controller: bills user-mode cycles against a programmable
// quantum, requests a context exchange from the program counter on expiry,
// captures the interrupted PC and waits for the OS to restore the context.
module context_exchange_ctrl #(
  parameter int unsigned ADDR_W          = 12,
  parameter int unsigned QUANTUM_W       = 8,
  parameter int unsigned DEFAULT_QUANTUM = 100,
  parameter int unsigned OS_BASE         = 1024
) (
  input  logic                 clock,
  input  logic                 resetCPU,
  input  logic [ADDR_W-1:0]    programCounter,
  input  logic                 HLT,
  input  logic                 preempt_enable,
  input  logic                 load_quantum,
  input  logic [QUANTUM_W-1:0] quantum_in,
  input  logic                 ctx_restore,
  output logic                 jump_context_exchange,
  output logic [ADDR_W-1:0]    saved_pc,
  output logic                 saved_valid,
  output logic [QUANTUM_W-1:0] quantum_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    FIRE    = 2'd2,
    OS_WAIT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0]    OS_BASE_PC  = ADDR_W'(OS_BASE);
  localparam logic [QUANTUM_W-1:0] QUANTUM_RST = QUANTUM_W'(DEFAULT_QUANTUM);
  localparam logic [QUANTUM_W-1:0] QUANTUM_ONE = QUANTUM_W'(1);

  state_t               state;
  state_t               state_next;
  logic [QUANTUM_W-1:0] quantum_reg;

  // Datapath controls produced by the output process.
  logic                 reload;
  logic                 capture;
  logic                 release_ctx;

  // A cycle is billed only when the core is running user code.
  logic user_tick;
  logic decrement;
  logic expire;

  assign user_tick = ~HLT & (programCounter < OS_BASE_PC);
  // Never decrement from zero, so the count cannot wrap.
  assign decrement = (state == COUNT) & user_tick & (quantum_count != '0);
  assign expire    = decrement & (quantum_count == QUANTUM_ONE);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (resetCPU) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; disabling preemption always wins over expiry.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (preempt_enable && (quantum_reg != '0)) state_next = COUNT;
      end
      COUNT: begin
        if (!preempt_enable) state_next = IDLE;
        else if (expire)     state_next = FIRE;
      end
      FIRE: begin
        if (!preempt_enable) state_next = IDLE;
        else if (!HLT)       state_next = OS_WAIT;
      end
      OS_WAIT: begin
        if (ctx_restore) begin
          if ((quantum_reg == '0) || !preempt_enable) state_next = IDLE;
          else                                        state_next = COUNT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs and datapath strobes; the request is combinational on HLT because
  // the program counter gives HLT priority and a halted request would be lost.
  always_comb begin
    jump_context_exchange = 1'b0;
    reload                = 1'b0;
    capture               = 1'b0;
    release_ctx           = 1'b0;
    unique case (state)
      IDLE: begin
        reload = (state_next == COUNT);
      end
      COUNT: begin
      end
      FIRE: begin
        jump_context_exchange = preempt_enable & ~HLT;
        capture               = preempt_enable & ~HLT;
      end
      OS_WAIT: begin
        reload      = ctx_restore;
        release_ctx = ctx_restore;
      end
      default: begin
      end
    endcase
  end

  // Quantum register, running count and saved context.
  always_ff @(posedge clock) begin
    if (resetCPU) begin
      quantum_reg   <= QUANTUM_RST;
      quantum_count <= '0;
      saved_pc      <= '0;
      saved_valid   <= 1'b0;
    end else begin
      // A new quantum length only affects the next reload.
      if (load_quantum) quantum_reg <= quantum_in;

      if (reload) begin
        quantum_count <= (state_next == COUNT) ? quantum_reg : '0;
      end else if (decrement) begin
        quantum_count <= quantum_count - QUANTUM_ONE;
      end

      // The instruction at the captured PC is uncommitted; the OS resumes there.
      if (capture) begin
        saved_pc    <= programCounter;
        saved_valid <= 1'b1;
      end else if (release_ctx) begin
        saved_valid <= 1'b0;
      end
    end
  end

endmodule
